// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: default line settings,
// the transmit FSM state type and counter-width helpers.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 9600;
    localparam int DATA_BITS        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Width of the per-bit clock counter that spans 0..bit_cyc-1.
    function automatic int bit_cnt_w(input int bit_cyc);
        return (bit_cyc > 1) ? $clog2(bit_cyc) : 1;
    endfunction

    // Width of the data-bit index that spans 0..n_bits-1.
    function automatic int idx_w(input int n_bits);
        return (n_bits > 1) ? $clog2(n_bits) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty, same-cycle read and
// write, and first-word-fall-through read data (head visible before the pop).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance is judged on the registered flags, so a same-cycle pop never
    // unblocks a write into a full FIFO.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's accepted write and/or read.
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    // Byte storage.
    // NOTE: storage is not reset; entries are only read after being written, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised
// LSB first onto rs232_tx, back to back while the FIFO has data.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_ovf,
    output logic       tx_busy,
    output logic       rs232_tx
);

    localparam int               BIT_CYC  = CLK_FREQ / BAUD;
    localparam int               CW       = bit_cnt_w(BIT_CYC);
    localparam int               IW       = idx_w(DATA_BITS);
    localparam logic [CW-1:0]    BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(DATA_BITS - 1);

    tx_state_e    state;
    tx_state_e    state_d;
    logic [CW-1:0] bit_cnt;
    logic [IW-1:0] idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          bit_end;
    logic          pop;
    logic          line_d;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign bit_end = (bit_cnt == BIT_LAST);
    assign tx_busy = (state != ST_IDLE);

    // Next state, FIFO pop and the line level belonging to the current state.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        line_d  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                line_d = 1'b0;
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                line_d = shift[0];
                if (bit_end && idx == IDX_LAST) state_d = ST_STOP;
            end
            ST_STOP: begin
                line_d = 1'b1;
                if (bit_end) begin
                    if (!tx_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and the flop that drives the serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rs232_tx <= 1'b1;
        end else begin
            state    <= state_d;
            rs232_tx <= line_d;
        end
    end

    // Baud counter, bit index and shift register; a pop hands the head byte to the shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            idx     <= '0;
            shift   <= '0;
        end else if (pop) begin
            shift   <= head;
            bit_cnt <= '0;
            idx     <= '0;
        end else if (state == ST_IDLE) begin
            bit_cnt <= '0;
        end else if (bit_end) begin
            bit_cnt <= '0;
            if (state == ST_DATA) begin
                shift <= {1'b0, shift[7:1]};
                idx   <= idx + 1'b1;
            end
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Overflow pulse: a write arrived while the FIFO was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_ovf <= 1'b0;
        else        tx_ovf <= tx_wr && tx_full;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered with 16 clocks per bit. A
// behavioural line receiver decodes rs232_tx into a byte queue that is compared
// against the bytes the bench expects the transmitter to send.
module tb_uart_tx_buffered;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 16;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_ovf;
    logic       tx_busy;
    logic       rs232_tx;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned ovf_seen = 0;
    bit          rx_en = 1'b0;
    logic [7:0]  rx_q [$];
    int unsigned rx_t [$];

    uart_tx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_ovf   (tx_ovf),
        .tx_busy  (tx_busy),
        .rs232_tx (rs232_tx)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_ovf === 1'b1) ovf_seen++;

    // Line receiver: find a start bit, sample mid-bit, push the decoded byte.
    initial begin : rx_model
        int unsigned t0;
        logic [7:0]  b;
        forever begin
            @(negedge clk);
            if (rx_en && rst_n && rs232_tx === 1'b0) begin
                t0 = cyc;
                b  = 8'h00;
                repeat (BIT_CYC / 2) @(negedge clk);
                checks++;
                if (rs232_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_start_mid got %b want 0 at cyc %0d", rs232_tx, cyc);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    b[i] = rs232_tx;
                end
                repeat (BIT_CYC) @(negedge clk);
                checks++;
                if (rs232_tx !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_stop_bit got %b want 1 at cyc %0d", rs232_tx, cyc);
                end
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    // Write one byte per cycle; first_edge is the rising edge that takes the first byte.
    task automatic drive_burst(input logic [7:0] bytes [$], output int unsigned first_edge);
        first_edge = 0;
        foreach (bytes[i]) begin
            @(negedge clk);
            if (i == 0) first_edge = cyc + 1;
            tx_data = bytes[i];
            tx_wr   = 1'b1;
        end
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input string name);
        int budget;
        budget = n * FRAME + 4 * FRAME;
        while (rx_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (rx_q.size() < n) begin
            errors++;
            $display("FAIL %s_rx_timeout got %0d bytes want %0d", name, rx_q.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = (DEPTH + 4) * FRAME;
        while ((tx_busy !== 1'b0 || tx_empty !== 1'b1) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy %b empty %b want 0 1", name, tx_busy, tx_empty);
        end
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic compare_stream(input logic [7:0] exp_q [$], input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= rx_q.size()) begin
                errors++;
                $display("FAIL %s_byte%0d got none want %h", name, i, exp_q[i]);
            end else if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d got %h want %h", name, i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got %0d want %0d", name, rx_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (rs232_tx !== 1'b1) begin errors++; $display("FAIL reset_line got %b want 1", rs232_tx); end
        if (tx_busy  !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        if (tx_full  !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", tx_full); end
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", tx_empty); end
        if (tx_ovf   !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", tx_ovf); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One 0xA5 frame checked clock by clock against the 8N1 bit pattern.
    task automatic test_single();
        logic [7:0]  q [$];
        logic [9:0]  frame;
        int unsigned n;
        int          bad;
        logic        busy_late;
        logic        exp_bit;
        rx_q.delete(); rx_t.delete();
        rx_en = 1'b1;
        q.push_back(8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        drive_burst(q, n);
        checks += 2;
        if (rs232_tx !== 1'b1) begin errors++; $display("FAIL single_line_n0 got %b want 1", rs232_tx); end
        if (tx_empty !== 1'b0) begin errors++; $display("FAIL single_empty_n0 got %b want 0", tx_empty); end
        wait_until(n + 1);
        checks += 3;
        if (rs232_tx !== 1'b1) begin errors++; $display("FAIL single_line_n1 got %b want 1", rs232_tx); end
        if (tx_busy  !== 1'b1) begin errors++; $display("FAIL single_busy_n1 got %b want 1", tx_busy); end
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL single_empty_n1 got %b want 1", tx_empty); end
        wait_until(n + 2);
        busy_late = 1'b0;
        for (int j = 0; j < 10; j++) begin
            bad = 0;
            exp_bit = frame[j];
            for (int s = 0; s < BIT_CYC; s++) begin
                if (j != 0 || s != 0) @(negedge clk);
                if (rs232_tx !== exp_bit) bad++;
                if (j == 9 && s == BIT_CYC - 2) busy_late = tx_busy;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL single_bit%0d got %0d wrong clocks want 0 (level %b)", j, bad, exp_bit);
            end
        end
        checks += 2;
        if (busy_late !== 1'b1) begin errors++; $display("FAIL single_busy_n160 got %b want 1", busy_late); end
        if (tx_busy   !== 1'b0) begin errors++; $display("FAIL single_busy_n161 got %b want 0", tx_busy); end
        @(negedge clk);
        checks++;
        if (rs232_tx !== 1'b1) begin errors++; $display("FAIL single_idle_after got %b want 1", rs232_tx); end
        wait_rx(1, "single");
        compare_stream(q, "single");
        wait_idle("single");
    endtask

    // Three bytes in consecutive cycles give three contiguous frames.
    task automatic test_back_to_back();
        logic [7:0]  q [$];
        int unsigned n;
        rx_q.delete(); rx_t.delete();
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55);
        drive_burst(q, n);
        wait_until(n + 2 * FRAME);
        checks++;
        if (tx_empty !== 1'b0) begin errors++; $display("FAIL b2b_empty_before_pop3 got %b want 0", tx_empty); end
        wait_until(n + 2 * FRAME + 1);
        checks++;
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty_after_pop3 got %b want 1", tx_empty); end
        wait_rx(3, "b2b");
        compare_stream(q, "b2b");
        if (rx_t.size() >= 3) begin
            checks += 3;
            if (rx_t[0] != n + 2) begin errors++; $display("FAIL b2b_start0 got %0d want %0d", rx_t[0], n + 2); end
            if (rx_t[1] - rx_t[0] != FRAME) begin errors++; $display("FAIL b2b_gap01 got %0d want %0d", rx_t[1] - rx_t[0], FRAME); end
            if (rx_t[2] - rx_t[1] != FRAME) begin errors++; $display("FAIL b2b_gap12 got %0d want %0d", rx_t[2] - rx_t[1], FRAME); end
        end
        wait_idle("b2b");
    endtask

    // 17 writes in 17 cycles all fit (first byte already popped); the next overflows.
    task automatic test_overflow();
        logic [7:0]  q [$];
        logic [7:0]  extra [$];
        int unsigned n;
        int unsigned m;
        int unsigned ovf0;
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < DEPTH + 1; i++) q.push_back(8'($urandom));
        extra.push_back(8'($urandom));
        ovf0 = ovf_seen;
        drive_burst(q, n);
        checks += 2;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_full_after17 got %b want 1", tx_full); end
        if (tx_ovf  !== 1'b0) begin errors++; $display("FAIL ovf_no_pulse17 got %b want 0", tx_ovf); end
        drive_burst(extra, m);
        checks += 2;
        if (tx_ovf  !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", tx_ovf); end
        if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_still_full got %b want 1", tx_full); end
        @(negedge clk);
        checks++;
        if (tx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got %b want 0", tx_ovf); end
        wait_rx(DEPTH + 1, "ovf");
        wait_idle("ovf");
        compare_stream(q, "ovf");
        checks++;
        if (ovf_seen - ovf0 != 1) begin errors++; $display("FAIL ovf_pulse_count got %0d want 1", ovf_seen - ovf0); end
    endtask

    // Full FIFO: a write in the same cycle as a pop is still rejected.
    task automatic test_full_pop();
        logic [7:0]  q [$];
        int unsigned n;
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < DEPTH + 1; i++) q.push_back(8'($urandom));
        drive_burst(q, n);
        wait_until(n + FRAME);
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL fullpop_full_before got %b want 1", tx_full); end
        tx_data = 8'hEE;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        checks += 2;
        if (tx_ovf  !== 1'b1) begin errors++; $display("FAIL fullpop_ovf got %b want 1", tx_ovf); end
        if (tx_full !== 1'b0) begin errors++; $display("FAIL fullpop_full_after got %b want 0", tx_full); end
        wait_rx(DEPTH + 1, "fullpop");
        wait_idle("fullpop");
        compare_stream(q, "fullpop");
    endtask

    // Reset in the middle of a data bit abandons the frame and flushes the FIFO.
    task automatic test_reset_mid();
        logic [7:0]  q [$];
        logic [7:0]  after [$];
        int unsigned n;
        int          bad;
        rx_en = 1'b0;
        q.push_back(8'h3C); q.push_back(8'($urandom)); q.push_back(8'($urandom));
        drive_burst(q, n);
        wait_until(n + 2 + 7 * BIT_CYC + BIT_CYC / 2);
        checks++;
        if (rs232_tx !== 1'b0) begin errors++; $display("FAIL rstmid_line_before got %b want 0", rs232_tx); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (rs232_tx !== 1'b1) begin errors++; $display("FAIL rstmid_line got %b want 1", rs232_tx); end
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b want 1", tx_empty); end
        if (tx_busy  !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", tx_busy); end
        if (tx_full  !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b want 0", tx_full); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_residual got %0d active clocks want 0", bad); end
        rx_q.delete(); rx_t.delete();
        rx_en = 1'b1;
        after.push_back(8'h81);
        drive_burst(after, n);
        wait_rx(1, "rstmid");
        wait_idle("rstmid");
        compare_stream(after, "rstmid");
    endtask

    // 40 random bytes at a rate-limited pace; pointers wrap more than twice.
    task automatic test_wrap();
        logic [7:0]  q [$];
        logic [7:0]  one [$];
        int unsigned n;
        int unsigned ovf0;
        rx_q.delete(); rx_t.delete();
        ovf0 = ovf_seen;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(80, 200)) @(negedge clk);
            one.delete();
            one.push_back(8'($urandom));
            q.push_back(one[0]);
            drive_burst(one, n);
        end
        wait_rx(40, "wrap");
        wait_idle("wrap");
        compare_stream(q, "wrap");
        checks++;
        if (ovf_seen != ovf0) begin errors++; $display("FAIL wrap_ovf got %0d pulses want 0", ovf_seen - ovf0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
